// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch: four-digit BCD stopwatch, 00.00 to 59.99 s in hundredths.
// Buttons are synchronized and edge-detected; digit 3 is blanked when zero.
module bcd_stopwatch #(
    parameter int TICK_DIV = 500000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START_STOP,
    input  logic       CLEAR,
    output logic [3:0] DIG0,
    output logic [3:0] DIG1,
    output logic [3:0] DIG2,
    output logic [3:0] DIG3,
    output logic       EN0,
    output logic       EN1,
    output logic       EN2,
    output logic       EN3,
    output logic       RUNNING,
    output logic       OVF
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PSC_MAX = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PSC_ONE = PW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t        state;
    logic          ss_s1;
    logic          ss_s2;
    logic          ss_prev;
    logic          cl_s1;
    logic          cl_s2;
    logic          cl_prev;
    logic [1:0]    warm;
    logic          armed;
    logic          ss_ev;
    logic          cl_ev;
    logic          clr_go;
    logic          tick;
    logic          at_max;
    logic [PW-1:0] psc;

    // Synchronize both buttons and keep the previous synchronized level.
    // The warm-up counter keeps the edge detector quiet until the chain
    // holds real samples, so a button held through reset is not an event.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ss_s1   <= 1'b0;
            ss_s2   <= 1'b0;
            ss_prev <= 1'b0;
            cl_s1   <= 1'b0;
            cl_s2   <= 1'b0;
            cl_prev <= 1'b0;
            warm    <= 2'd0;
        end else begin
            ss_s1   <= START_STOP;
            ss_s2   <= ss_s1;
            ss_prev <= ss_s2;
            cl_s1   <= CLEAR;
            cl_s2   <= cl_s1;
            cl_prev <= cl_s2;
            if (warm != 2'd3) begin
                warm <= warm + 2'd1;
            end
        end
    end

    assign armed  = (warm == 2'd3);
    assign ss_ev  = armed & ss_s2 & ~ss_prev;
    assign cl_ev  = armed & cl_s2 & ~cl_prev;
    assign clr_go = (state == PAUSE) & cl_ev;
    assign tick   = (state == RUN) & (psc == PSC_MAX);
    assign at_max = (DIG3 == 4'd5) & (DIG2 == 4'd9)
                  & (DIG1 == 4'd9) & (DIG0 == 4'd9);

    // Run-control FSM; clear beats start/stop only while paused.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            RUNNING <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ss_ev) begin
                        state   <= RUN;
                        RUNNING <= 1'b1;
                    end
                end
                RUN: begin
                    if (ss_ev) begin
                        state   <= PAUSE;
                        RUNNING <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (cl_ev) begin
                        state   <= IDLE;
                        RUNNING <= 1'b0;
                    end else if (ss_ev) begin
                        state   <= RUN;
                        RUNNING <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    RUNNING <= 1'b0;
                end
            endcase
        end
    end

    // Prescaler advances only in RUN and holds its partial count in PAUSE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            psc <= '0;
        end else if (clr_go) begin
            psc <= '0;
        end else if (tick) begin
            psc <= '0;
        end else if (state == RUN) begin
            psc <= psc + PSC_ONE;
        end
    end

    // Cascaded BCD count; 59.99 rolls over to 00.00.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            DIG0 <= 4'd0;
            DIG1 <= 4'd0;
            DIG2 <= 4'd0;
            DIG3 <= 4'd0;
        end else if (clr_go) begin
            DIG0 <= 4'd0;
            DIG1 <= 4'd0;
            DIG2 <= 4'd0;
            DIG3 <= 4'd0;
        end else if (tick) begin
            if (DIG0 >= 4'd9) begin
                DIG0 <= 4'd0;
                if (DIG1 >= 4'd9) begin
                    DIG1 <= 4'd0;
                    if (DIG2 >= 4'd9) begin
                        DIG2 <= 4'd0;
                        if (DIG3 >= 4'd5) begin
                            DIG3 <= 4'd0;
                        end else begin
                            DIG3 <= DIG3 + 4'd1;
                        end
                    end else begin
                        DIG2 <= DIG2 + 4'd1;
                    end
                end else begin
                    DIG1 <= DIG1 + 4'd1;
                end
            end else begin
                DIG0 <= DIG0 + 4'd1;
            end
        end
    end

    // Overflow pulse for the single cycle after the wrap edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OVF <= 1'b0;
        end else begin
            OVF <= tick & at_max;
        end
    end

    assign EN0 = 1'b1;
    assign EN1 = 1'b1;
    assign EN2 = 1'b1;
    assign EN3 = (DIG3 != 4'd0);

endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb_bcd_stopwatch: directed and random stimulus against an integer model
// of the stopwatch (count in hundredths, events from sampled history).
module tb_bcd_stopwatch;

    localparam int TD = 4;

    logic       CLK;
    logic       RST_N;
    logic       START_STOP;
    logic       CLEAR;
    logic [3:0] DIG0;
    logic [3:0] DIG1;
    logic [3:0] DIG2;
    logic [3:0] DIG3;
    logic       EN0;
    logic       EN1;
    logic       EN2;
    logic       EN3;
    logic       RUNNING;
    logic       OVF;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    bit cmp_en  = 0;

    // model state: count in hundredths, prescaler, state 0/1/2
    int       m_cnt;
    int       m_psc;
    int       m_st;
    bit       m_ovf;
    bit [2:0] hs;
    bit [2:0] hc;
    bit       sev;
    bit       cev;
    bit       tk;

    bcd_stopwatch #(.TICK_DIV(TD)) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .START_STOP(START_STOP),
        .CLEAR(CLEAR),
        .DIG0(DIG0),
        .DIG1(DIG1),
        .DIG2(DIG2),
        .DIG3(DIG3),
        .EN0(EN0),
        .EN1(EN1),
        .EN2(EN2),
        .EN3(EN3),
        .RUNNING(RUNNING),
        .OVF(OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model. Raw levels seen before reset release count as
    // high, so a button held through reset never looks like a new press.
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_cnt = 0;
            m_psc = 0;
            m_st  = 0;
            m_ovf = 0;
            hs    = 3'b111;
            hc    = 3'b111;
        end else begin
            sev = hs[1] & ~hs[2];
            cev = hc[1] & ~hc[2];
            hs  = {hs[1:0], START_STOP};
            hc  = {hc[1:0], CLEAR};
            tk  = (m_st == 1) && (m_psc == TD - 1);
            m_ovf = 0;
            if (m_st == 2 && cev) begin
                m_cnt = 0;
                m_psc = 0;
            end else if (m_st == 1) begin
                if (tk) begin
                    m_psc = 0;
                    m_ovf = (m_cnt == 5999);
                    m_cnt = (m_cnt + 1) % 6000;
                end else begin
                    m_psc = m_psc + 1;
                end
            end
            case (m_st)
                0: if (sev) m_st = 1;
                1: if (sev) m_st = 2;
                2: begin
                    if (cev) m_st = 0;
                    else if (sev) m_st = 1;
                end
                default: m_st = 0;
            endcase
        end
    end

    function automatic logic [21:0] model_vec();
        logic [21:0] v;
        v = {4'(m_cnt / 1000), 4'((m_cnt / 100) % 10),
             4'((m_cnt / 10) % 10), 4'(m_cnt % 10),
             (m_cnt >= 1000), 3'b111, (m_st == 1), m_ovf};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic press(input bit s, input bit c);
        @(negedge CLK);
        START_STOP = s;
        CLEAR      = c;
        @(negedge CLK);
        START_STOP = 1'b0;
        CLEAR      = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #3 RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        #2 RST_N = 1'b1;
        repeat (6) @(negedge CLK);
    endtask

    // Pulse start at a negedge; returns just after the RUN entry edge.
    task automatic start_run();
        @(negedge CLK);
        START_STOP = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        START_STOP = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
    endtask

    initial begin
        int  tr;
        bit  pr;
        RST_N      = 1'b0;
        START_STOP = 1'b0;
        CLEAR      = 1'b0;

        fork
            forever begin
                logic [21:0] act;
                logic [21:0] exp;
                @(negedge CLK);
                cyc++;
                if (cmp_en) begin
                    act = {DIG3, DIG2, DIG1, DIG0, EN3, EN2, EN1, EN0,
                           RUNNING, OVF};
                    exp = model_vec();
                    vectors++;
                    if (act !== exp) begin
                        errors++;
                        $display("FAIL cycle %0d: got %h expected %h",
                                 cyc, act, exp);
                    end
                end
            end
        join_none

        // reset values before any clock edge
        #1;
        chk("rst_dig", 32'({DIG3, DIG2, DIG1, DIG0}), 32'h0);
        chk("rst_en", 32'({EN3, EN2, EN1, EN0}), 32'h7);
        chk("rst_run", 32'(RUNNING), 32'h0);
        chk("rst_ovf", 32'(OVF), 32'h0);
        cmp_en = 1'b1;
        repeat (3) @(negedge CLK);
        #2 RST_N = 1'b1;
        repeat (6) @(negedge CLK);

        // start: RUNNING two edges after first sample, first step 4 later
        @(negedge CLK);
        START_STOP = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        START_STOP = 1'b0;
        @(posedge CLK);
        #1 chk("run_n1", 32'(RUNNING), 32'h0);
        @(posedge CLK);
        #1 chk("run_n2", 32'(RUNNING), 32'h1);
        repeat (3) @(posedge CLK);
        #1 chk("d0_r3", 32'(DIG0), 32'h0);
        @(posedge CLK);
        #1 chk("d0_r4", 32'(DIG0), 32'h1);
        repeat (35) @(posedge CLK);
        #1 START_STOP = 1'b1;
        @(posedge CLK);
        #1 chk("ten_ticks", 32'({DIG1, DIG0}), 32'h10);
        START_STOP = 1'b0;

        // pause with prescaler frozen at 2, then resume
        @(posedge CLK);
        #1 chk("pre_pause", 32'(RUNNING), 32'h1);
        @(posedge CLK);
        #1 chk("paused", 32'(RUNNING), 32'h0);
        repeat (100) @(posedge CLK);
        #1 chk("frozen", 32'({DIG3, DIG2, DIG1, DIG0}), 32'h0010);
        START_STOP = 1'b1;
        @(posedge CLK);
        #1 START_STOP = 1'b0;
        @(posedge CLK);
        #1 chk("res_n1", 32'(RUNNING), 32'h0);
        @(posedge CLK);
        #1 chk("resumed", 32'(RUNNING), 32'h1);
        @(posedge CLK);
        #1 chk("res_q1", 32'(DIG0), 32'h0);
        @(posedge CLK);
        #1 chk("res_q2", 32'(DIG0), 32'h1);

        // clear rules
        press(1'b0, 1'b1);
        chk("clr_in_run", 32'(RUNNING), 32'h1);
        press(1'b1, 1'b0);
        chk("to_pause", 32'(RUNNING), 32'h0);
        press(1'b0, 1'b1);
        chk("clr_pause", 32'({DIG3, DIG2, DIG1, DIG0, EN3, RUNNING}),
            32'h0);
        press(1'b1, 1'b0);
        repeat (20) @(negedge CLK);
        press(1'b1, 1'b0);
        press(1'b1, 1'b1);
        chk("both_pause", 32'({DIG3, DIG2, DIG1, DIG0, RUNNING}), 32'h0);
        press(1'b1, 1'b1);
        chk("both_idle", 32'(RUNNING), 32'h1);
        press(1'b1, 1'b1);
        chk("both_run", 32'(RUNNING), 32'h0);
        press(1'b0, 1'b1);

        // random button activity
        repeat (3000) begin
            @(negedge CLK);
            if ($urandom_range(7) == 0) START_STOP = ~START_STOP;
            if ($urandom_range(11) == 0) CLEAR = ~CLEAR;
        end
        START_STOP = 1'b0;
        CLEAR      = 1'b0;
        repeat (5) @(negedge CLK);

        // held button gives exactly one transition
        do_reset();
        @(negedge CLK);
        START_STOP = 1'b1;
        tr = 0;
        pr = RUNNING;
        repeat (50) begin
            @(negedge CLK);
            if (RUNNING != pr) tr++;
            pr = RUNNING;
        end
        START_STOP = 1'b0;
        chk("held_trans", 32'(tr), 32'd1);
        chk("held_run", 32'(RUNNING), 32'h1);

        // wrap and overflow, then EN3 back at 10.00
        do_reset();
        start_run();
        repeat (23999) @(posedge CLK);
        #1;
        chk("pre_wrap", 32'({DIG3, DIG2, DIG1, DIG0}), 32'h5999);
        chk("pre_wrap_ovf", 32'(OVF), 32'h0);
        chk("pre_wrap_en3", 32'(EN3), 32'h1);
        @(posedge CLK);
        #1;
        chk("wrap", 32'({DIG3, DIG2, DIG1, DIG0}), 32'h0);
        chk("wrap_ovf", 32'(OVF), 32'h1);
        chk("wrap_en3", 32'(EN3), 32'h0);
        chk("wrap_run", 32'(RUNNING), 32'h1);
        @(posedge CLK);
        #1 chk("post_wrap_ovf", 32'(OVF), 32'h0);
        repeat (3998) @(posedge CLK);
        #1 chk("en3_999", 32'(EN3), 32'h0);
        @(posedge CLK);
        #1;
        chk("en3_1000", 32'(EN3), 32'h1);
        chk("cnt_1000", 32'({DIG3, DIG2, DIG1, DIG0}), 32'h1000);

        // asynchronous reset mid-run at 12.34
        do_reset();
        start_run();
        repeat (4936) @(posedge CLK);
        #1 chk("cnt_1234", 32'({DIG3, DIG2, DIG1, DIG0}), 32'h1234);
        #3 RST_N = 1'b0;
        #1;
        chk("async_dig", 32'({DIG3, DIG2, DIG1, DIG0}), 32'h0);
        chk("async_ctl", 32'({EN3, EN2, EN1, EN0, RUNNING, OVF}),
            32'h1c);
        @(negedge CLK);
        #2 RST_N = 1'b1;
        repeat (10) @(posedge CLK);
        #1 chk("post_rst", 32'({DIG3, DIG2, DIG1, DIG0, RUNNING}), 32'h0);

        // button held across reset release is not an event
        @(posedge CLK);
        #3 RST_N = 1'b0;
        START_STOP = 1'b1;
        repeat (2) @(negedge CLK);
        #2 RST_N = 1'b1;
        repeat (20) @(negedge CLK);
        chk("held_rst", 32'(RUNNING), 32'h0);
        START_STOP = 1'b0;
        repeat (5) @(negedge CLK);
        press(1'b1, 1'b0);
        chk("after_held", 32'(RUNNING), 32'h1);
        repeat (10) @(negedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
